pwm_cfg_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one pwm_controller between NREQ requesters.

---
 rtl/pwm_cfg_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_arbiter.sv
// pwm_cfg_arbiter: round-robin sequencer that shares one pwm_controller
// between NREQ requesters. Each granted command (SET new PERIOD/DUTY, or
// STOP) is issued to the controller as a one-cycle pulse. The block then
// waits for the controller's RDY (or a timeout) and acknowledges the
// requester.
//
// Optional build macro: PWM_CFG_CHECK_EN. When it is defined, a SET whose
// PERIOD is 0, whose DUTY is 0, or whose DUTY exceeds PERIOD is rejected at
// grant time. The controller is left untouched, and ACK pulses together
// with ERR. When the macro is undefined, every command is forwarded and ERR
// stays 0.
module pwm_cfg_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int TO_CYC = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_op_i,
  input  logic [DW*NREQ-1:0]   req_period_i,
  input  logic [DW*NREQ-1:0]   req_duty_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      owner_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 err_o,
  input  logic                 pwm_rdy_i,
  output logic                 pwm_set_o,
  output logic                 pwm_stop_o,
  output logic [DW-1:0]        pwm_period_o,
  output logic [DW-1:0]        pwm_duty_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Registered outputs and command context.
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            err_q, err_d;
  logic            set_q, set_d;
  logic            stop_q, stop_d;
  logic [DW-1:0]   period_q, period_d;
  logic [DW-1:0]   duty_q, duty_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Per-requester config viewed as arrays for indexed selection.
  logic [DW-1:0]   per_arr  [NREQ];
  logic [DW-1:0]   duty_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign per_arr[g]  = req_period_i[DW*g +: DW];
    assign duty_arr[g] = req_duty_i[DW*g +: DW];
  end

  // One-hot encode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef PWM_CFG_CHECK_EN
  // A SET config the controller must never see.
  function automatic logic cfg_invalid(input logic [DW-1:0] per,
                                       input logic [DW-1:0] dut);
    return (per == '0) || (dut == '0) || (dut > per);
  endfunction
`endif

  // Round-robin search: first requester after the pointer, wrapping.
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;

  // Combinational round-robin winner selection.
  always_comb begin : arb
    logic [IW-1:0] cand;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!gnt_vld && req_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Rejection of the candidate command (SET only, never STOP).
  logic reject;

  // Config legality check of the current arbitration winner.
  always_comb begin
`ifdef PWM_CFG_CHECK_EN
    reject = !req_op_i[gnt_idx] && cfg_invalid(per_arr[gnt_idx], duty_arr[gnt_idx]);
`else
    reject = 1'b0;
`endif
  end

  // WAIT exit conditions. RDY is ignored in the first WAIT cycle because the
  // controller may not have dropped it yet in response to the pulse.
  logic [CW-1:0] cnt_inc;
  logic          wait_rdy;
  logic          wait_to;

  assign cnt_inc  = cnt_q + 1'b1;
  assign wait_rdy = pwm_rdy_i && (cnt_q != '0);
  assign wait_to  = !wait_rdy && (cnt_inc == CW'(TO_CYC));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld && pwm_rdy_i) begin
          state_d = reject ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wait_rdy || wait_to) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and context next values. Pulses default low; held values default
  // to their current contents.
  always_comb begin
    ack_d     = '0;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    set_d     = 1'b0;
    stop_d    = 1'b0;
    owner_d   = owner_q;
    period_d  = period_q;
    duty_d    = duty_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    busy_d    = (state_d != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (state_d != S_IDLE) begin
          ptr_d = gnt_idx;
          gnt_d = gnt_idx;
          op_d  = req_op_i[gnt_idx];
          if (reject) begin
            // Rejected SET: acknowledge at once, controller untouched.
            ack_d = onehot(gnt_idx);
            err_d = 1'b1;
          end else begin
            period_d = per_arr[gnt_idx];
            duty_d   = duty_arr[gnt_idx];
            set_d    = !req_op_i[gnt_idx];
            stop_d   = req_op_i[gnt_idx];
          end
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (state_d == S_DONE) begin
          // Ownership follows the command even when RDY never came back.
          ack_d     = onehot(gnt_q);
          timeout_d = wait_to;
          owner_d   = op_q ? '0 : onehot(gnt_q);
        end
      end
      default: ;
    endcase
  end

  // Output and context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      set_q     <= 1'b0;
      stop_q    <= 1'b0;
      period_q  <= '0;
      duty_q    <= '0;
      ptr_q     <= IW'(NREQ - 1);
      gnt_q     <= '0;
      op_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      set_q     <= set_d;
      stop_q    <= stop_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ack_o        = ack_q;
  assign owner_o      = owner_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;
  assign err_o        = err_q;
  assign pwm_set_o    = set_q;
  assign pwm_stop_o   = stop_q;
  assign pwm_period_o = period_q;
  assign pwm_duty_o   = duty_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Testbench for pwm_cfg_arbiter (NREQ=4, DW=8, TO_CYC=8).
// Expected ACK/OWNER/TIMEOUT/ERR results are queued when a command is posted.
// A negedge monitor pops and compares them whenever ACK pulses.
module tb_pwm_cfg_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int TO_CYC = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req, req_op;
  logic [DW*NREQ-1:0]  req_period, req_duty;
  logic                pwm_rdy;
  logic [NREQ-1:0]     ack_o, owner_o;
  logic                busy_o, timeout_o, err_o, pwm_set_o, pwm_stop_o;
  logic [DW-1:0]       pwm_period_o, pwm_duty_o;

  always #5 clk = ~clk;

  pwm_cfg_arbiter #(.NREQ(NREQ), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .req_op_i     (req_op),
    .req_period_i (req_period),
    .req_duty_i   (req_duty),
    .ack_o        (ack_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .err_o        (err_o),
    .pwm_rdy_i    (pwm_rdy),
    .pwm_set_o    (pwm_set_o),
    .pwm_stop_o   (pwm_stop_o),
    .pwm_period_o (pwm_period_o),
    .pwm_duty_o   (pwm_duty_o)
  );

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] owner;
    logic            to;
    logic            err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0, set_cnt = 0, stop_cnt = 0, busy_lo_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [NREQ-1:0] a, input logic [NREQ-1:0] o,
                          input logic t, input logic e);
    exp_t x;
    x.ack   = a;
    x.owner = o;
    x.to    = t;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Monitor: event counters plus the scoreboard compare on every ACK.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pwm_set_o)  set_cnt     <= set_cnt + 1;
      if (pwm_stop_o) stop_cnt    <= stop_cnt + 1;
      if (!busy_o)    busy_lo_cnt <= busy_lo_cnt + 1;
      if (ack_o != '0) begin
        ack_cnt <= ack_cnt + 1;
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'(ack_o), 32'(0));
        end else begin
          chk("ack_grant",   32'(ack_o),     32'(exp_q[0].ack));
          chk("ack_owner",   32'(owner_o),   32'(exp_q[0].owner));
          chk("ack_timeout", 32'(timeout_o), 32'(exp_q[0].to));
          chk("ack_err",     32'(err_o),     32'(exp_q[0].err));
          exp_q.delete(0);
        end
      end else if (timeout_o || err_o) begin
        chk("flag_without_ack", 32'({timeout_o, err_o}), 32'(0));
      end
    end
  end

  task automatic wait_ack(input int n, input int budget, output int cyc);
    cyc = 0;
    while (ack_cnt < n && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("ack_wait", 32'(ack_cnt), 32'(n));
  endtask

  task automatic wait_set(input int n, input int budget);
    int c;
    c = 0;
    while (set_cnt < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("set_wait", 32'(set_cnt), 32'(n));
  endtask

  task automatic set_cmd(input int idx, input logic op, input logic [DW-1:0] per,
                         input logic [DW-1:0] dty);
    req_op[idx]             = op;
    req_period[DW*idx +: DW] = per;
    req_duty[DW*idx +: DW]   = dty;
  endtask

  // Post one command, wait for its ACK, then drop REQ on the following edge.
  task automatic run_cmd(input int idx, input logic op, input logic [DW-1:0] per,
                         input logic [DW-1:0] dty, input logic [NREQ-1:0] exp_owner,
                         input logic exp_to, input logic exp_err);
    int a, cyc;
    push_exp(NREQ'(1 << idx), exp_owner, exp_to, exp_err);
    set_cmd(idx, op, per, dty);
    a = ack_cnt;
    req[idx] = 1'b1;
    wait_ack(a + 1, 40, cyc);
    @(posedge clk); #1;
    req[idx] = 1'b0;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc, s0, s1, t0, a0, a1, b0, b1, bad, g;
    rst_n = 1'b0; req = '0; req_op = '0; req_period = '0; req_duty = '0;
    pwm_rdy = 1'b1;

    // Test 1: reset values, then a single SET from requester 0.
    set_cmd(0, 1'b0, 8'd100, 8'd30);
    req = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({ack_o, owner_o, busy_o, timeout_o, err_o, pwm_set_o,
                               pwm_stop_o, pwm_period_o, pwm_duty_o}), 32'(0));
    push_exp(4'b0001, 4'b0001, 1'b0, 1'b0);
    s0 = set_cnt; a0 = ack_cnt;
    rst_n = 1'b1;
    wait_set(s0 + 1, 10);
    wait_ack(a0 + 1, 10, cyc);
    chk("t1_set_to_ack_cycles", 32'(cyc), 32'(3));
    chk("t1_set_pulse_cycles", 32'(set_cnt - s0), 32'(1));
    chk("t1_period", 32'(pwm_period_o), 32'(100));
    chk("t1_duty", 32'(pwm_duty_o), 32'(30));
    @(posedge clk); #1;
    req = '0;

    // Test 2: all four requesting, each re-raised after its ACK.
    hold_reset();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 8'(50 + 10 * i), 8'(10 + i));
    for (int k = 0; k < 5; k++) push_exp(NREQ'(1 << (k % 4)), NREQ'(1 << (k % 4)), 1'b0, 1'b0);
    a0 = ack_cnt; b0 = 0; b1 = 0;
    req = 4'b1111;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      wait_ack(a0 + k + 1, 30, cyc);
      if (k == 0) b0 = busy_lo_cnt;
      if (k == 4) b1 = busy_lo_cnt;
      if (k < 4) begin
        @(posedge clk); #1; req[g] = 1'b0;
        @(posedge clk); #1; req[g] = 1'b1;
      end else begin
        @(posedge clk); #1; req = '0;
      end
    end
    chk("t2_idle_cycles_between_cmds", 32'(b1 - b0), 32'(4));

    // Test 3: PERIOD/DUTY stable from ISSUE until the next grant.
    push_exp(4'b0100, 4'b0100, 1'b0, 1'b0);
    s0 = set_cnt; a0 = ack_cnt; bad = 0;
    set_cmd(2, 1'b0, 8'd200, 8'd50);
    req[2] = 1'b1;
    wait_set(s0 + 1, 10);
    if (pwm_period_o != 8'd200 || pwm_duty_o != 8'd50) bad++;
    cyc = 0;
    while (ack_cnt < a0 + 1 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
      if (pwm_period_o != 8'd200 || pwm_duty_o != 8'd50) bad++;
    end
    chk("t3_ack", 32'(ack_cnt), 32'(a0 + 1));
    @(posedge clk); #1;
    req[2] = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (pwm_period_o != 8'd200 || pwm_duty_o != 8'd50) bad++;
    end
    chk("t3_cfg_stable", 32'(bad), 32'(0));
    run_cmd(0, 1'b0, 8'd120, 8'd60, 4'b0001, 1'b0, 1'b0);
    chk("t3_next_grant_period", 32'(pwm_period_o), 32'(120));

    // Test 4: STOP from requester 1 clears ownership.
    s0 = set_cnt; t0 = stop_cnt;
    run_cmd(1, 1'b1, 8'd0, 8'd0, 4'b0000, 1'b0, 1'b0);
    chk("t4_stop_pulse_cycles", 32'(stop_cnt - t0), 32'(1));
    chk("t4_no_set", 32'(set_cnt - s0), 32'(0));
    chk("t4_owner_cleared", 32'(owner_o), 32'(0));

    // Test 5: RDY stuck low after ISSUE -> timeout, then no grant while RDY=0.
    push_exp(4'b1000, 4'b1000, 1'b1, 1'b0);
    s0 = set_cnt; a0 = ack_cnt;
    set_cmd(3, 1'b0, 8'd70, 8'd35);
    req[3] = 1'b1;
    wait_set(s0 + 1, 10);
    pwm_rdy = 1'b0;
    wait_ack(a0 + 1, 20, cyc);
    chk("t5_issue_to_ack_cycles", 32'(cyc), 32'(TO_CYC + 1));
    @(posedge clk); #1;
    req[3] = 1'b0;
    set_cmd(0, 1'b0, 8'd90, 8'd45);
    req[0] = 1'b1;
    s1 = set_cnt; a1 = ack_cnt;
    repeat (10) begin
      @(negedge clk); #1;
    end
    chk("t5_no_set_while_not_rdy", 32'(set_cnt - s1), 32'(0));
    chk("t5_not_busy_while_not_rdy", 32'(busy_o), 32'(0));
    chk("t5_no_ack_while_not_rdy", 32'(ack_cnt), 32'(a1));
    push_exp(4'b0001, 4'b0001, 1'b0, 1'b0);
    pwm_rdy = 1'b1;
    wait_ack(a1 + 1, 20, cyc);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("t5_period_after_rdy", 32'(pwm_period_o), 32'(90));

    // Test 6: SET with DUTY > PERIOD, then a boundary SET with DUTY == PERIOD.
    s0 = set_cnt;
`ifdef PWM_CFG_CHECK_EN
    run_cmd(2, 1'b0, 8'd10, 8'd20, 4'b0001, 1'b0, 1'b1);
    chk("t6_rejected_no_set", 32'(set_cnt - s0), 32'(0));
    chk("t6_rejected_period", 32'(pwm_period_o), 32'(90));
    chk("t6_rejected_duty", 32'(pwm_duty_o), 32'(45));
`else
    run_cmd(2, 1'b0, 8'd10, 8'd20, 4'b0100, 1'b0, 1'b0);
    chk("t6_forwarded_set", 32'(set_cnt - s0), 32'(1));
    chk("t6_forwarded_period", 32'(pwm_period_o), 32'(10));
    chk("t6_forwarded_duty", 32'(pwm_duty_o), 32'(20));
`endif
    run_cmd(3, 1'b0, 8'd40, 8'd40, 4'b1000, 1'b0, 1'b0);
    chk("t6_equal_duty_period", 32'(pwm_period_o), 32'(40));

    // Test 7: asynchronous reset in the middle of a command.
    s0 = set_cnt; a0 = ack_cnt;
    set_cmd(1, 1'b0, 8'd60, 8'd20);
    req[1] = 1'b1;
    wait_set(s0 + 1, 10);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t7_async_reset_outputs", 32'({ack_o, owner_o, busy_o, timeout_o, err_o, pwm_set_o,
                                        pwm_stop_o, pwm_period_o, pwm_duty_o}), 32'(0));
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
    end
    chk("t7_no_ack_for_aborted", 32'(ack_cnt), 32'(a0));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
